// File: rtl/mult_div_pkg.sv
// Shared op codes, FSM encoding and default width for the HI/LO multiply/divide unit.
// No logic lives here; latency and backpressure belong to the users of this package.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_OP_MULT  = 4'b1000;
    localparam logic [3:0] ALU_OP_DIV   = 4'b1001;
    localparam logic [3:0] ALU_OP_MFHI  = 4'b1011;
    localparam logic [3:0] ALU_OP_MFLO  = 4'b1100;
    localparam logic [3:0] ALU_OP_MULTU = 4'b1101;
    localparam logic [3:0] ALU_OP_DIVU  = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mult_div_iter_step.sv
// One unsigned iteration: conditional add + right shift (mul) or restoring trial subtract + left shift (div).
// Purely combinational, zero latency; no flow control.
module mult_div_iter_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {acc, mq[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};
        acc_nxt = sum[WIDTH:1];
        mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        if (is_div) begin
            // Borrow out of the trial subtract means the partial remainder is restored.
            if (diff[WIDTH+1]) begin
                acc_nxt = shifted[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt = diff[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative mult/div owning HI/LO; MULT_DIV_UNSIGNED_EN adds multu/divu (ALU_Op 13/14).
// Latency: Start accepted at edge 0, Done pulse and new HI/LO in cycle WIDTH+2.
// Backpressure: Stall asserted combinationally while Busy for any mult/div/mfhi/mflo in EX.
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       ALU_Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             Div_By_Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Move_Result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             neg_prod_q, neg_prod_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             start_mul, start_div, signed_op, stall_op;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_acc, step_mq;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    always_comb begin
        start_mul = 1'b0;
        start_div = 1'b0;
        signed_op = 1'b1;
        stall_op  = 1'b0;
        case (ALU_Op)
            ALU_OP_MULT: begin start_mul = 1'b1; stall_op = 1'b1; end
            ALU_OP_DIV:  begin start_div = 1'b1; stall_op = 1'b1; end
            ALU_OP_MFHI, ALU_OP_MFLO: stall_op = 1'b1;
`ifdef MULT_DIV_UNSIGNED_EN
            ALU_OP_MULTU: begin start_mul = 1'b1; signed_op = 1'b0; stall_op = 1'b1; end
            ALU_OP_DIVU:  begin start_div = 1'b1; signed_op = 1'b0; stall_op = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Unsigned ops clear the sign flags, so FIX leaves their results untouched.
    always_comb begin
        sign_a = signed_op & Operand_A[WIDTH-1];
        sign_b = signed_op & Operand_B[WIDTH-1];
        abs_a  = sign_a ? -Operand_A : Operand_A;
        abs_b  = sign_b ? -Operand_B : Operand_B;
    end

    mult_div_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (state_q == ST_DIV),
        .acc     (acc_q),
        .mq      (mq_q),
        .opnd    (opnd_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq)
    );

    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = neg_prod_q ? -prod : prod;
        quo_fix  = neg_prod_q ? -mq_q : mq_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        div_d      = div_q;
        neg_prod_d = neg_prod_q;
        neg_rem_d  = neg_rem_q;
        dbz_d      = dbz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start && (start_mul || start_div)) begin
                    state_d    = start_mul ? ST_MUL : ST_DIV;
                    cnt_d      = '0;
                    acc_d      = '0;
                    mq_d       = start_mul ? abs_b : abs_a;
                    opnd_d     = start_mul ? abs_a : abs_b;
                    div_d      = start_div;
                    neg_prod_d = sign_a ^ sign_b;
                    neg_rem_d  = sign_a;
                    dbz_d      = start_div && (Operand_B == '0);
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (!div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dbz_q) begin
                    // Unsigned remainder equals |A|; restoring its sign yields Operand_A.
                    hi_d = rem_fix;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            div_q      <= div_d;
            neg_prod_q <= neg_prod_d;
            neg_rem_q  <= neg_rem_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        Busy        = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        Done        = (state_q == ST_DONE);
        Div_By_Zero = (state_q == ST_DONE) && dbz_q;
        Stall       = Busy && Start && stall_op;
        HI          = hi_q;
        LO          = lo_q;
        Move_Result = '0;
        if (ALU_Op == ALU_OP_MFHI) begin
            Move_Result = hi_q;
        end else if (ALU_Op == ALU_OP_MFLO) begin
            Move_Result = lo_q;
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: directed scenarios plus randomized traffic against a cycle-count model.
module tb_mult_div_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  ALU_Op = 4'd0;
    logic [31:0] Operand_A = 32'd0;
    logic [31:0] Operand_B = 32'd0;
    logic        Busy, Stall, Done, Div_By_Zero;
    logic [31:0] HI, LO, Move_Result;

    int total = 0;
    int bad = 0;

    mult_div_sequencer #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .ALU_Op      (ALU_Op),
        .Operand_A   (Operand_A),
        .Operand_B   (Operand_B),
        .Busy        (Busy),
        .Stall       (Stall),
        .Done        (Done),
        .Div_By_Zero (Div_By_Zero),
        .HI          (HI),
        .LO          (LO),
        .Move_Result (Move_Result)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic starts_op(input logic [3:0] op);
`ifdef MULT_DIV_UNSIGNED_EN
        return op == 4'd8 || op == 4'd9 || op == 4'd13 || op == 4'd14;
`else
        return op == 4'd8 || op == 4'd9;
`endif
    endfunction

    function automatic logic stalls_op(input logic [3:0] op);
        return starts_op(op) || op == 4'd11 || op == 4'd12;
    endfunction

    // Architectural result {div_by_zero, HI, LO} straight from signed/unsigned arithmetic.
    function automatic logic [64:0] golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb, q, r;
        sa = a;
        sb = b;
        case (op)
            4'd8: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, p};
            end
            4'd9: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'd0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
`ifdef MULT_DIV_UNSIGNED_EN
            4'd13: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            4'd14: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
`endif
            default: return 65'd0;
        endcase
    endfunction

    // Model: m_age counts cycles since the accepting edge (0 = no operation outstanding).
    int          m_age = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, r_hi = 32'd0, r_lo = 32'd0;
    logic        r_dbz = 1'b0;
    logic [64:0] g_res;

    assign g_res = golden(ALU_Op, Operand_A, Operand_B);

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_age <= 0;
            m_hi  <= 32'd0;
            m_lo  <= 32'd0;
        end else if (Start && starts_op(ALU_Op) && (m_age == 0 || m_age == 34)) begin
            m_age <= 1;
            r_dbz <= g_res[64];
            r_hi  <= g_res[63:32];
            r_lo  <= g_res[31:0];
        end else if (m_age == 34) begin
            m_age <= 0;
        end else if (m_age > 0) begin
            m_age <= m_age + 1;
            if (m_age == 33) begin
                m_hi <= r_hi;
                m_lo <= r_lo;
            end
        end
    end

    always @(negedge Clk) begin
        chk("busy", 65'(Busy), 65'(m_age >= 1 && m_age <= 33));
        chk("done", 65'(Done), 65'(m_age == 34));
        chk("div_by_zero", 65'(Div_By_Zero), 65'(m_age == 34 && r_dbz));
        chk("stall", 65'(Stall), 65'(m_age >= 1 && m_age <= 33 && Start && stalls_op(ALU_Op)));
        chk("hi", 65'(HI), 65'(m_hi));
        chk("lo", 65'(LO), 65'(m_lo));
        chk("move_result", 65'(Move_Result),
            65'(ALU_Op == 4'd11 ? m_hi : (ALU_Op == 4'd12 ? m_lo : 32'd0)));
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = s;
        ALU_Op = op;
        Operand_A = a;
        Operand_B = b;
    endtask

    // Leaves the bench in cycle 1 of the operation with inputs idle.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_in(1'b1, op, a, b);
        tick();
        set_in(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt;
        logic [3:0] ops [8];
        ops = '{4'd8, 4'd9, 4'd11, 4'd12, 4'd13, 4'd14, 4'd0, 4'd10};

        chk("gold_mult_7x-3", golden(4'd8, 32'd7, 32'hFFFFFFFD), {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
        chk("gold_div_-7/2", golden(4'd9, 32'hFFFFFFF9, 32'd2), {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("gold_div_ovf", golden(4'd9, 32'h80000000, 32'hFFFFFFFF), {1'b0, 32'd0, 32'h80000000});
        chk("gold_div_zero", golden(4'd9, 32'd5, 32'd0), {1'b1, 32'd5, 32'hFFFFFFFF});
        chk("gold_mult_2^32", golden(4'd8, 32'h10000, 32'h10000), {1'b0, 32'd1, 32'd0});

        repeat (2) tick();
        chk("reset_hi_lo", {1'b0, HI, LO}, 65'd0);
        chk("reset_busy_done", 65'({Busy, Done, Div_By_Zero}), 65'd0);
        Reset_n = 1'b1;
        tick();

        start_op(4'd8, 32'd7, 32'hFFFFFFFD);
        chk("mult_busy_c1", 65'(Busy), 65'd1);
        repeat (32) tick();
        chk("mult_busy_c33", 65'({Busy, Done}), 65'b10);
        tick();
        chk("mult_done_c34", 65'({Busy, Done}), 65'b01);
        chk("mult_result", {1'b0, HI, LO}, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
        tick();
        chk("mult_done_c35", 65'(Done), 65'd0);

        start_op(4'd9, 32'hFFFFFFF9, 32'd2);
        repeat (33) tick();
        chk("div_-7/2", {1'b0, HI, LO}, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});

        start_op(4'd9, 32'h80000000, 32'hFFFFFFFF);
        repeat (33) tick();
        chk("div_ovf", {1'b0, HI, LO}, {1'b0, 32'd0, 32'h80000000});

        start_op(4'd9, 32'd5, 32'd0);
        repeat (32) tick();
        chk("dbz_c33", 65'({Div_By_Zero, Done}), 65'b00);
        tick();
        chk("dbz_c34", 65'({Div_By_Zero, Done}), 65'b11);
        chk("dbz_result", {1'b0, HI, LO}, {1'b0, 32'd5, 32'hFFFFFFFF});
        tick();
        chk("dbz_c35", 65'({Div_By_Zero, Done}), 65'b00);

        start_op(4'd8, 32'h10000, 32'h10000);
        set_in(1'b1, 4'd11, 32'd0, 32'd0);
        #1;
        chk("mfhi_stall_c1", 65'(Stall), 65'd1);
        repeat (32) tick();
        chk("mfhi_stall_c33", 65'(Stall), 65'd1);
        tick();
        chk("mfhi_stall_c34", 65'(Stall), 65'd0);
        chk("mfhi_move_c34", 65'(Move_Result), 65'd1);
        tick();
        set_in(1'b0, 4'd0, 32'd0, 32'd0);

        start_op(4'd9, 32'd100, 32'd7);
        repeat (9) tick();
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_div", {1'b0, HI, LO}, 65'd0);
        chk("rst_mid_busy", 65'(Busy), 65'd0);
        tick();
        Reset_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) dcnt++;
        end
        chk("rst_no_done", 65'(dcnt), 65'd0);

        start_op(4'd8, 32'd3, 32'd4);
        repeat (33) tick();
        chk("post_rst_mult", {1'b0, Done, HI, LO}, {1'b1, 32'd0, 32'd12});
        set_in(1'b1, 4'd8, 32'd2, 32'd5);
        tick();
        set_in(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (32) tick();
        chk("b2b_done_c33", 65'(Done), 65'd0);
        tick();
        chk("b2b_done_c34", {1'b0, Done, HI, LO}, {1'b1, 32'd0, 32'd10});

        start_op(4'd8, 32'hFFFFFFFF, 32'h12345678);
        repeat (4) tick();
        set_in(1'b1, 4'd9, 32'd100, 32'd3);
        #1;
        chk("div_in_mult_stall", 65'(Stall), 65'd1);
        tick();
        set_in(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (28) tick();
        chk("mult_ignores_div", {1'b0, Done, HI, LO}, {1'b1, 32'hFFFFFFFF, 32'hEDCBA988});
        tick();
        chk("no_div_after", 65'(Busy), 65'd0);

        for (int i = 0; i < 4000; i++) begin
            Reset_n = ($urandom_range(0, 699) != 0);
            set_in($urandom_range(0, 1) == 1, ops[$urandom_range(0, 7)], rnd_opnd(), rnd_opnd());
            tick();
        end
        Reset_n = 1'b1;
        set_in(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
